// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC and fetches opcode (plus movi immediate)
// bytes over a req/ack program-memory handshake, issuing one instruction per pass.
module inst_fetch #(
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [7:0]        memData,
  output logic [7:0]        inst,
  output logic              instValid,
  output logic [7:0]        immData,
  output logic              immValid,
  input  logic              loadAddr,
  input  logic [ADDR_W-1:0] jumpTarget,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [4:0] OP_MOVI = 5'b00010;

  typedef enum logic [1:0] {
    FETCH,
    IMM,
    ISSUE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [7:0]        r_inst;
  logic [7:0]        w_inst_nxt;
  logic [7:0]        r_imm;
  logic [7:0]        w_imm_nxt;
  logic              w_req;
  logic              w_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_ADDR;
      r_inst  <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_imm_nxt   = r_imm;
    w_req       = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req = run;
        if (run && memAck) begin
          w_inst_nxt  = memData;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = (memData[7:3] == OP_MOVI) ? IMM : ISSUE;
        end
      end
      IMM: begin
        // Once the opcode is in, the immediate is fetched regardless of run.
        w_req = 1'b1;
        if (memAck) begin
          w_imm_nxt   = memData;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (loadAddr) begin
          w_pc_nxt = jumpTarget;
        end
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Request is gated by rst so it drops the instant reset asserts, even though
  // the reset state itself (FETCH) would otherwise request while run=1.
  assign memReq    = w_req & ~rst;
  assign memAddr   = r_pc;
  assign pc        = r_pc;
  assign instValid = w_issue;
  assign inst      = w_issue ? r_inst : 8'h00;
  assign immValid  = w_issue && (r_inst[7:3] == OP_MOVI);
  assign immData   = r_imm;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory and control-unit models, with memory
// accesses and issued instructions checked against scoreboard queues.
module tb_inst_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memAck;
  logic [7:0] memData;
  logic [7:0] inst;
  logic       instValid;
  logic [7:0] immData;
  logic       immValid;
  logic       loadAddr;
  logic [7:0] jumpTarget;
  logic [7:0] pc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  mem [256];
  logic        hold_zero;
  int unsigned cnt;

  typedef struct {
    logic [7:0]  addr;
    int unsigned cyc;
  } acc_t;

  typedef struct {
    logic [7:0]  inst;
    logic        imv;
    logic [7:0]  imm;
    int unsigned gap;
    logic [7:0]  pc_after;
  } iss_t;

  acc_t acc_q[$];
  iss_t iss_q[$];

  inst_fetch #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .inst(inst), .instValid(instValid), .immData(immData), .immValid(immValid),
    .loadAddr(loadAddr), .jumpTarget(jumpTarget), .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory: ack not gated by memReq, so the DUT must ignore stray acks.
  assign memData = mem[memAddr];
  assign memAck  = !(hold_zero && memAddr == 8'h00) &&
                   (cnt >= ((memAddr == 8'h09) ? 32'd3 : 32'd0));

  always @(posedge clk) begin
    if (memReq && !memAck) cnt <= cnt + 1;
    else                   cnt <= 0;
  end

  // Control unit: opcode 01101 is jmp, low register bits pick the target.
  always_comb begin
    loadAddr = instValid && (inst[7:3] == 5'b01101);
    case (inst[1:0])
      2'd0:    jumpTarget = 8'h40;
      2'd1:    jumpTarget = 8'h05;
      default: jumpTarget = 8'hFF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_acc(input logic [7:0] a, input int unsigned c);
    acc_t e;
    e.addr = a; e.cyc = c;
    acc_q.push_back(e);
  endtask

  task automatic push_iss(input logic [7:0] i, input logic v, input logic [7:0] m,
                          input int unsigned g, input logic [7:0] p);
    iss_t e;
    e.inst = i; e.imv = v; e.imm = m; e.gap = g; e.pc_after = p;
    iss_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int unsigned cycle = 0;
  int unsigned last_issue = 0;
  int unsigned cur = 0;
  logic        pc_pending = 1'b0;
  logic [7:0]  pc_exp;

  always @(negedge clk) begin
    acc_t a;
    iss_t s;
    cycle++;
    if (pc_pending) begin
      chk("pc_after_issue", pc, pc_exp);
      pc_pending = 1'b0;
    end
    if (memReq) begin
      cur++;
      if (memAck) begin
        chk("access_expected", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          chk("mem_addr", memAddr, a.addr);
          chk("req_cycles", cur, a.cyc);
        end
        cur = 0;
      end
    end else begin
      cur = 0;
    end
    if (instValid) begin
      chk("issue_expected", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        s = iss_q.pop_front();
        chk("inst", inst, s.inst);
        chk("imm_valid", immValid, s.imv);
        if (s.imv) chk("imm_data", immData, s.imm);
        if (s.gap != 0) chk("issue_gap", cycle - last_issue, s.gap);
        pc_exp     = s.pc_after;
        pc_pending = 1'b1;
      end
      last_issue = cycle;
    end else begin
      chk("idle_inst_nop", inst, 8'h00);
      chk("idle_imm_valid", immValid, 1'b0);
    end
  end

  initial begin
    int unsigned budget;
    rst       = 1'b1;
    run       = 1'b1;
    hold_zero = 1'b0;
    cnt       = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h41; mem[8'h02] = 8'h42;
    mem[8'h03] = 8'h68; mem[8'h40] = 8'h69;
    mem[8'h05] = 8'h10; mem[8'h06] = 8'h5A;
    mem[8'h07] = 8'h41; mem[8'h08] = 8'h00; mem[8'h09] = 8'h42;
    mem[8'h0A] = 8'h6A; mem[8'hFF] = 8'h10;

    // Program run: adds, two jumps, movi, nop, slow access, jump to FF.
    push_acc(8'h00, 1); push_acc(8'h01, 1); push_acc(8'h02, 1); push_acc(8'h03, 1);
    push_acc(8'h40, 1); push_acc(8'h05, 1); push_acc(8'h06, 1); push_acc(8'h07, 1);
    push_acc(8'h08, 1); push_acc(8'h09, 4); push_acc(8'h0A, 1); push_acc(8'hFF, 1);
    push_iss(8'h40, 0, 8'h00, 0, 8'h01);
    push_iss(8'h41, 0, 8'h00, 2, 8'h02);
    push_iss(8'h42, 0, 8'h00, 2, 8'h03);
    push_iss(8'h68, 0, 8'h00, 2, 8'h40);
    push_iss(8'h69, 0, 8'h00, 2, 8'h05);
    push_iss(8'h10, 1, 8'h5A, 3, 8'h07);
    push_iss(8'h41, 0, 8'h00, 2, 8'h08);
    push_iss(8'h00, 0, 8'h00, 2, 8'h09);
    push_iss(8'h42, 0, 8'h00, 5, 8'h0A);
    push_iss(8'h6A, 0, 8'h00, 2, 8'hFF);

    step(); step();
    chk("rst_memReq", memReq, 1'b0);
    chk("rst_inst", inst, 8'h00);
    chk("rst_instValid", instValid, 1'b0);
    chk("rst_immValid", immValid, 1'b0);
    chk("rst_immData", immData, 8'h00);
    chk("rst_pc", pc, 8'h00);

    rst = 1'b0;
    #1;
    chk("first_memReq", memReq, 1'b1);
    chk("first_memAddr", memAddr, 8'h00);

    budget = 0;
    while (pc == 8'h00 && budget < 50) begin step(); budget++; end
    chk("wait_first_fetch", budget < 50, 1);
    hold_zero = 1'b1;

    // Reach the movi at FF whose immediate (addr wrapped to 00) is never acked.
    budget = 0;
    while (!(memReq && memAddr == 8'h00) && budget < 300) begin step(); budget++; end
    chk("wait_imm_stall", budget < 300, 1);
    step(); step();
    chk("stall_memReq", memReq, 1'b1);
    chk("stall_memAddr_wrap", memAddr, 8'h00);
    chk("stall_instValid", instValid, 1'b0);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("iss_q_drained", iss_q.size(), 0);

    rst = 1'b1;
    #1;
    chk("midrst_memReq", memReq, 1'b0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_inst", inst, 8'h00);

    push_acc(8'h00, 1); push_acc(8'h01, 1);
    push_iss(8'h40, 0, 8'h00, 0, 8'h01);
    push_iss(8'h41, 0, 8'h00, 0, 8'h02);
    step();
    rst       = 1'b0;
    hold_zero = 1'b0;
    #1;
    chk("refetch_memReq", memReq, 1'b1);
    chk("refetch_memAddr", memAddr, 8'h00);

    budget = 0;
    while (!instValid && budget < 50) begin step(); budget++; end
    chk("wait_refetch_issue", budget < 50, 1);
    step();
    run = 1'b0;
    #1;
    chk("stall_run_memReq", memReq, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_run_memReq", memReq, 1'b0);
      chk("stall_run_pc", pc, 8'h01);
    end
    run = 1'b1;

    budget = 0;
    while (iss_q.size() != 0 && budget < 50) begin step(); budget++; end
    chk("wait_final_issue", budget < 50, 1);
    run = 1'b0;
    repeat (3) step();
    chk("final_acc_q", acc_q.size(), 0);
    chk("final_iss_q", iss_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
